pwl_table_loader: RTL and testbench

- Runtime writer for the PWL evaluator's coefficient tables, replacing static ROM contents with RAM contents loaded at runtime.
- Accepts a valid/ready word stream carrying one bias word and then 2^addr_width {offset, slope} words for one setting.
- Emits registered write strobes, addresses and data for the bias RAM and the segment RAM.
- Sits between the host/config path and the PWL coefficient RAMs.

---
 rtl/pwl_table_loader.sv | 130 +++++++++++++
 tb/tb_pwl_table_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_table_loader.sv
// Runtime loader for the PWL evaluator's coefficient RAMs: turns a valid/ready word stream
// (one bias word, then 2^addr_width {offset, slope} words) into registered RAM write strobes.
module pwl_table_loader #(
    parameter int setting_width = 1,
    parameter int addr_width    = 1,
    parameter int offset_width  = 1,
    parameter int slope_width   = 1,
    parameter int bias_width    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_start,
    input  logic [setting_width-1:0]            load_setting,
    input  logic                                abort,
    input  logic [offset_width+slope_width-1:0] in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                seg_we,
    output logic [setting_width+addr_width-1:0] seg_waddr,
    output logic [offset_width+slope_width-1:0] seg_wdata,
    output logic                                bias_we,
    output logic [setting_width-1:0]            bias_waddr,
    output logic [bias_width-1:0]               bias_wdata,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic [1:0]                          fsm_state
);

    typedef enum logic [1:0] {IDLE, BIAS, SEG, DONE} state_t;

    state_t                   state, state_next;
    logic [setting_width-1:0] setting, setting_next;
    logic [addr_width-1:0]    idx, idx_next;
    logic                     accept;
    logic                     seg_we_next, bias_we_next, done_next, aborted_next;

    // Stream handshake: a word transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on the state, never on in_valid.
    assign in_ready  = (state == BIAS) || (state == SEG);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            setting <= '0;
            idx     <= '0;
        end else begin
            state   <= state_next;
            setting <= setting_next;
            idx     <= idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        setting_next = setting;
        idx_next     = idx;
        seg_we_next  = 1'b0;
        bias_we_next = 1'b0;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    setting_next = load_setting;
                    idx_next     = '0;
                    state_next   = BIAS;
                end
            end
            BIAS: begin
                // abort takes priority: a beat accepted alongside it is discarded
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else if (accept) begin
                    bias_we_next = 1'b1;
                    state_next   = SEG;
                end
            end
            SEG: begin
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else if (accept) begin
                    seg_we_next = 1'b1;
                    idx_next    = idx + 1'b1;
                    if (idx == {addr_width{1'b1}}) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write ports: strobes last one cycle; address/data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_we     <= 1'b0;
            seg_waddr  <= '0;
            seg_wdata  <= '0;
            bias_we    <= 1'b0;
            bias_waddr <= '0;
            bias_wdata <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            seg_we  <= seg_we_next;
            bias_we <= bias_we_next;
            done    <= done_next;
            aborted <= aborted_next;
            if (seg_we_next) begin
                seg_waddr <= {setting, idx};
                seg_wdata <= in_data;
            end
            if (bias_we_next) begin
                bias_waddr <= setting;
                bias_wdata <= in_data[bias_width-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pwl_table_loader.sv
// Directed bench for pwl_table_loader: expected RAM writes are queued as beats are driven
// and popped by a monitor when the write strobes appear.
module tb_pwl_table_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [0:0]  load_setting = '0;
    logic        abort = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        seg_we;
    logic [2:0]  seg_waddr;
    logic [15:0] seg_wdata;
    logic        bias_we;
    logic [0:0]  bias_waddr;
    logic [7:0]  bias_wdata;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [1:0]  fsm_state;

    pwl_table_loader #(
        .setting_width(1),
        .addr_width   (2),
        .offset_width (8),
        .slope_width  (8),
        .bias_width   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_setting(load_setting),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .seg_we      (seg_we),
        .seg_waddr   (seg_waddr),
        .seg_wdata   (seg_wdata),
        .bias_we     (bias_we),
        .bias_waddr  (bias_waddr),
        .bias_wdata  (bias_wdata),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    int aborted_cnt = 0;

    logic [18:0] seg_q[$];   // {setting, index, word}
    logic [8:0]  bias_q[$];  // {setting, bias}
    logic [0:0]  cur_setting = '0;
    logic [1:0]  cur_idx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bias_we) begin
            if (bias_q.size() == 0) begin
                total++;
                $error("FAIL bias_unexpected: observed write %0h expected none", {bias_waddr, bias_wdata});
            end else begin
                check("bias_write", {bias_waddr, bias_wdata}, bias_q.pop_front());
            end
        end
        if (seg_we) begin
            if (seg_q.size() == 0) begin
                total++;
                $error("FAIL seg_unexpected: observed write %0h expected none", {seg_waddr, seg_wdata});
            end else begin
                check("seg_write", {seg_waddr, seg_wdata}, seg_q.pop_front());
            end
        end
        if (done) done_cnt++;
        if (aborted) aborted_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [0:0] s);
        load_start   = 1'b1;
        load_setting = s;
        cur_setting  = s;
        cur_idx      = '0;
        tick();
        load_start   = 1'b0;
    endtask

    // Drives one word until accepted; an abort beat is expected to produce no write.
    task automatic beat(input logic [15:0] w, input bit is_bias, input bit rand_valid, input bit do_abort);
        bit v;
        int tries = 0;
        do begin
            v = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tries >= 20) v = 1'b1;
            tries++;
            in_valid = v;
            in_data  = w;
            abort    = do_abort && v;
            check("in_ready_loading", in_ready, 1);
            if (v && !do_abort) begin
                if (is_bias) begin
                    bias_q.push_back({cur_setting, w[7:0]});
                end else begin
                    seg_q.push_back({cur_setting, cur_idx, w});
                    cur_idx++;
                end
            end
            tick();
        end while (!v);
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic full_load(input logic [0:0] s, input logic [15:0] b, input bit rand_valid);
        start(s);
        beat(b, 1'b1, rand_valid, 1'b0);
        for (int i = 0; i < 4; i++) beat(16'h1111 * (i + 1) + {8'h0, b[7:0]}, 1'b0, rand_valid, 1'b0);
        check("done_state_ready", in_ready, 0);
        check("done_state_busy", busy, 1);
        check("done_early", done, 0);
        tick();
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_we", {seg_we, bias_we, done, aborted}, 0);
        check("rst_seg_regs", {seg_waddr, seg_wdata}, 0);
        check("rst_bias_regs", {bias_waddr, bias_wdata}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        check("idle_ignores_valid", busy, 0);
        in_valid = 1'b0;

        // Full load, setting 1, valid held high; done 7 cycles after load_start
        start(1);
        check("bias_busy", busy, 1);
        beat(16'h0005, 1'b1, 1'b0, 1'b0);
        beat(16'h1020, 1'b0, 1'b0, 1'b0);
        beat(16'h3040, 1'b0, 1'b0, 1'b0);
        beat(16'h5060, 1'b0, 1'b0, 1'b0);
        beat(16'h7080, 1'b0, 1'b0, 1'b0);
        check("full_done_state_ready", in_ready, 0);
        check("full_done_early", done, 0);
        tick();
        check("full_done_pulse", done, 1);
        check("full_busy_low", busy, 0);
        tick();
        check("full_done_one_cycle", done, 0);

        // Backpressure from the source, setting 0
        full_load(0, 16'h0042, 1'b1);

        // Abort on the beat with index 1
        start(1);
        beat(16'h00AA, 1'b1, 1'b0, 1'b0);
        beat(16'h1234, 1'b0, 1'b0, 1'b0);
        beat(16'h5678, 1'b0, 1'b0, 1'b1);
        check("abort_ready_low", in_ready, 0);
        check("abort_busy_low", busy, 0);
        check("abort_pulse", aborted, 1);
        check("abort_no_write", seg_we, 0);
        check("abort_no_done", done, 0);
        tick();
        check("abort_one_cycle", aborted, 0);
        abort = 1'b1;
        tick();
        check("abort_idle_no_effect", aborted, 0);
        abort = 1'b0;

        // load_start while busy is ignored
        start(1);
        beat(16'h0011, 1'b1, 1'b0, 1'b0);
        load_start   = 1'b1;
        load_setting = 1'b0;
        beat(16'h2222, 1'b0, 1'b0, 1'b0);
        load_start   = 1'b0;
        beat(16'h3333, 1'b0, 1'b0, 1'b0);
        beat(16'h4444, 1'b0, 1'b0, 1'b0);
        beat(16'h5555, 1'b0, 1'b0, 1'b0);
        tick();
        check("busy_start_done", done, 1);

        // Asynchronous reset during SEG drops the pending write
        start(0);
        beat(16'h0077, 1'b1, 1'b0, 1'b0);
        beat(16'h9999, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_seg_we", seg_we, 0);
        check("arst_queue_drained", seg_q.size(), 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Fresh load after reset with bias truncation (0xABCD -> 0xCD)
        full_load(1, 16'hABCD, 1'b0);
        tick();

        check("done_count", done_cnt, 4);
        check("aborted_count", aborted_cnt, 1);
        check("seg_q_empty", seg_q.size(), 0);
        check("bias_q_empty", bias_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
